// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with per-frame shadow latching,
// hex font decode, blanking, blink and decimal points. Outputs are active-low.
module seven_seg_scan_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DEAD_CYCLES = 2,
    parameter int unsigned BLINK_DIV   = 250
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode_active,
    output logic                    frame_done
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0]           prescaler_q, prescaler_d;
    logic [SW-1:0]           scan_idx_q, scan_idx_d;
    logic [FW-1:0]           frame_cnt_q, frame_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d;
    logic [6:0]              segments_q, segments_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    frame_done_q, frame_done_d;

    logic       slot_tick;
    logic       frame_boundary;
    logic       digit_dark;
    logic [3:0] cur_nibble;
    logic [6:0] font_seg;

    assign slot_tick      = (prescaler_q == PW'(REFRESH_DIV - 1));
    assign frame_boundary = slot_tick && (scan_idx_q == SW'(NUM_DIGITS - 1));

    // Counters and the once-per-frame shadow capture.
    always_comb begin
        prescaler_d   = slot_tick ? '0 : prescaler_q + PW'(1);
        scan_idx_d    = scan_idx_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        sh_digits_d   = sh_digits_q;
        sh_dp_d       = sh_dp_q;
        sh_blank_d    = sh_blank_q;
        sh_blink_d    = sh_blink_q;
        if (slot_tick) begin
            scan_idx_d = frame_boundary ? '0 : scan_idx_q + SW'(1);
        end
        if (frame_boundary) begin
            sh_digits_d = digits_in;
            sh_dp_d     = dp_in;
            sh_blank_d  = blank_in;
            sh_blink_d  = blink_in;
            if (frame_cnt_q == FW'(BLINK_DIV - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end
    end

    always_comb begin
        cur_nibble = sh_digits_q[4*int'(scan_idx_q) +: 4];
        unique case (cur_nibble)
            4'h0: font_seg = 7'h01;
            4'h1: font_seg = 7'h4F;
            4'h2: font_seg = 7'h12;
            4'h3: font_seg = 7'h06;
            4'h4: font_seg = 7'h4C;
            4'h5: font_seg = 7'h24;
            4'h6: font_seg = 7'h20;
            4'h7: font_seg = 7'h0F;
            4'h8: font_seg = 7'h00;
            4'h9: font_seg = 7'h04;
            4'hA: font_seg = 7'h08;
            4'hB: font_seg = 7'h60;
            4'hC: font_seg = 7'h31;
            4'hD: font_seg = 7'h42;
            4'hE: font_seg = 7'h30;
            default: font_seg = 7'h38;
        endcase
    end

    // Dead time at the start of each slot keeps the previous digit from ghosting.
    always_comb begin
        digit_dark   = sh_blank_q[scan_idx_q] || (sh_blink_q[scan_idx_q] && blink_phase_q);
        segments_d   = 7'h7F;
        dp_d         = 1'b1;
        anode_d      = '1;
        frame_done_d = frame_boundary;
        if ((32'(prescaler_q) >= DEAD_CYCLES) && !digit_dark) begin
            anode_d[scan_idx_q] = 1'b0;
            segments_d          = font_seg;
            dp_d                = ~sh_dp_q[scan_idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_q   <= '0;
            scan_idx_q    <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            sh_digits_q   <= '0;
            sh_dp_q       <= '0;
            sh_blank_q    <= '1;
            sh_blink_q    <= '0;
            segments_q    <= 7'h7F;
            dp_q          <= 1'b1;
            anode_q       <= '1;
            frame_done_q  <= 1'b0;
        end else begin
            prescaler_q   <= prescaler_d;
            scan_idx_q    <= scan_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            sh_digits_q   <= sh_digits_d;
            sh_dp_q       <= sh_dp_d;
            sh_blank_q    <= sh_blank_d;
            sh_blink_q    <= sh_blink_d;
            segments_q    <= segments_d;
            dp_q          <= dp_d;
            anode_q       <= anode_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign segments     = segments_q;
    assign dp           = dp_q;
    assign anode_active = anode_q;
    assign frame_done   = frame_done_q;

endmodule
